// File: rtl/intersection_phase_sched_if.sv
// Request/lamp bundle between the intersection phase scheduler and its environment.
// Latency: none, wires only.
// Backpressure: none; requests are level or pulse inputs, lamps and phase are status outputs.
// Ports: side_req, ped_req, night_mode (only with NIGHT_FLASH_EN) towards the scheduler;
//        led_a, led_b, ped_walk, phase from the scheduler. slave = scheduler side, master = driver side.
interface intersection_phase_sched_if;
    logic       side_req;
    logic       ped_req;
`ifdef NIGHT_FLASH_EN
    logic       night_mode;
`endif
    logic [2:0] led_a;
    logic [2:0] led_b;
    logic       ped_walk;
    logic [2:0] phase;

`ifdef NIGHT_FLASH_EN
    modport master (output side_req, ped_req, night_mode,
                    input  led_a, led_b, ped_walk, phase);
    modport slave  (input  side_req, ped_req, night_mode,
                    output led_a, led_b, ped_walk, phase);
`else
    modport master (output side_req, ped_req,
                    input  led_a, led_b, ped_walk, phase);
    modport slave  (input  side_req, ped_req,
                    output led_a, led_b, ped_walk, phase);
`endif
endinterface

// File: rtl/intersection_phase_sched.sv
// Phase scheduler for main road A, side road B and a pedestrian crossing over A (active-low lamps).
// Latency: lamps, walk and phase are registered and change on the same edge as the phase change.
// Backpressure: none; side/pedestrian requests are latched until B_GREEN is entered.
// Ports: sys_clk, sys_rst (async, active-high), sched_if.slave (requests in, lamps/walk/phase out).
// Optional night flash (phase 6) is built only when the macro NIGHT_FLASH_EN is defined.
module intersection_phase_sched #(
    parameter int unsigned TICK_CYCLES = 24_000_000,
    parameter int unsigned T_GREEN_MIN = 10,
    parameter int unsigned T_B_GREEN   = 5,
    parameter int unsigned T_AMBER     = 2,
    parameter int unsigned T_ALLRED    = 1
) (
    input  logic                             sys_clk,
    input  logic                             sys_rst,
    intersection_phase_sched_if.slave        sched_if
);
    localparam logic [2:0] PH_A_GREEN   = 3'd0;
    localparam logic [2:0] PH_A_AMBER   = 3'd1;
    localparam logic [2:0] PH_ALLRED_AB = 3'd2;
    localparam logic [2:0] PH_B_GREEN   = 3'd3;
    localparam logic [2:0] PH_B_AMBER   = 3'd4;
    localparam logic [2:0] PH_ALLRED_BA = 3'd5;
`ifdef NIGHT_FLASH_EN
    localparam logic [2:0] PH_FLASH     = 3'd6;
`endif

    localparam logic [2:0] LAMP_RED    = 3'b011;
    localparam logic [2:0] LAMP_AMBER  = 3'b101;
    localparam logic [2:0] LAMP_GREEN  = 3'b110;
    localparam logic [2:0] AMBER_BIT   = 3'b010;

    localparam int unsigned TW      = $clog2(TICK_CYCLES);
    localparam int unsigned TMAX_G  = (T_GREEN_MIN > T_B_GREEN) ? T_GREEN_MIN : T_B_GREEN;
    localparam int unsigned TMAX_C  = (T_AMBER > T_ALLRED) ? T_AMBER : T_ALLRED;
    localparam int unsigned TMAX    = (TMAX_G > TMAX_C) ? TMAX_G : TMAX_C;
    localparam int unsigned PW      = $clog2(TMAX + 1);

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [PW-1:0] tmr_q, tmr_d;
    logic [2:0]    phase_q, phase_d;
    logic          side_pend_q, side_pend_d;
    logic          ped_pend_q, ped_pend_d;
    logic [2:0]    led_a_q, led_a_d;
    logic [2:0]    led_b_q, led_b_d;
    logic          walk_q, walk_d;
    logic          tick;
    logic          pend_any;
    logic          enter_b;
    logic          in_flash;

    always_comb begin
        tick       = (tick_cnt_q == TW'(TICK_CYCLES - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        // Same-cycle inputs count, so a request on the exit tick is not one tick late.
        pend_any   = side_pend_q | ped_pend_q | sched_if.side_req | sched_if.ped_req;

        phase_d = phase_q;
        case (phase_q)
            PH_A_GREEN:   if (tick && (tmr_q >= PW'(T_GREEN_MIN - 1)) && pend_any)
                              phase_d = PH_A_AMBER;
            PH_A_AMBER:   if (tick && (tmr_q == PW'(T_AMBER - 1)))   phase_d = PH_ALLRED_AB;
            PH_ALLRED_AB: if (tick && (tmr_q == PW'(T_ALLRED - 1)))  phase_d = PH_B_GREEN;
            PH_B_GREEN:   if (tick && (tmr_q == PW'(T_B_GREEN - 1))) phase_d = PH_B_AMBER;
            PH_B_AMBER:   if (tick && (tmr_q == PW'(T_AMBER - 1)))   phase_d = PH_ALLRED_BA;
            PH_ALLRED_BA: if (tick && (tmr_q == PW'(T_ALLRED - 1)))  phase_d = PH_A_GREEN;
`ifdef NIGHT_FLASH_EN
            PH_FLASH:     if (tick && !sched_if.night_mode)          phase_d = PH_ALLRED_BA;
`endif
            default:      phase_d = PH_ALLRED_BA;
        endcase

`ifdef NIGHT_FLASH_EN
        // Night flash may only start from states where A is green or both are red.
        if (tick && sched_if.night_mode &&
            ((phase_q == PH_A_GREEN) || (phase_q == PH_ALLRED_AB) || (phase_q == PH_ALLRED_BA)))
            phase_d = PH_FLASH;
        in_flash = (phase_d == PH_FLASH);
`else
        in_flash = 1'b0;
`endif

        if (phase_d != phase_q)
            tmr_d = '0;
        else if (tick && (tmr_q != {PW{1'b1}}))
            tmr_d = tmr_q + PW'(1);
        else
            tmr_d = tmr_q;

        // Clearing on B_GREEN entry wins over a request in that same cycle.
        enter_b = (phase_d == PH_B_GREEN) && (phase_q != PH_B_GREEN);
        if (enter_b || in_flash) begin
            side_pend_d = 1'b0;
            ped_pend_d  = 1'b0;
        end else begin
            side_pend_d = side_pend_q | sched_if.side_req;
            ped_pend_d  = ped_pend_q  | sched_if.ped_req;
        end

        led_a_d = LAMP_RED;
        led_b_d = LAMP_RED;
        walk_d  = 1'b0;
        case (phase_d)
            PH_A_GREEN: led_a_d = LAMP_GREEN;
            PH_A_AMBER: led_a_d = LAMP_AMBER;
            PH_B_GREEN: begin
                led_b_d = LAMP_GREEN;
                walk_d  = 1'b1;
            end
            PH_B_AMBER: led_b_d = LAMP_AMBER;
`ifdef NIGHT_FLASH_EN
            PH_FLASH: begin
                if (phase_q != PH_FLASH) begin
                    led_a_d = LAMP_AMBER;
                    led_b_d = LAMP_AMBER;
                end else if (tick) begin
                    led_a_d = led_a_q ^ AMBER_BIT;
                    led_b_d = led_b_q ^ AMBER_BIT;
                end else begin
                    led_a_d = led_a_q;
                    led_b_d = led_b_q;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tick_cnt_q  <= '0;
            tmr_q       <= '0;
            phase_q     <= PH_ALLRED_BA;
            side_pend_q <= 1'b0;
            ped_pend_q  <= 1'b0;
            led_a_q     <= LAMP_RED;
            led_b_q     <= LAMP_RED;
            walk_q      <= 1'b0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            tmr_q       <= tmr_d;
            phase_q     <= phase_d;
            side_pend_q <= side_pend_d;
            ped_pend_q  <= ped_pend_d;
            led_a_q     <= led_a_d;
            led_b_q     <= led_b_d;
            walk_q      <= walk_d;
        end
    end

    assign sched_if.led_a    = led_a_q;
    assign sched_if.led_b    = led_b_q;
    assign sched_if.ped_walk = walk_q;
    assign sched_if.phase    = phase_q;
endmodule

// File: tb/tb_intersection_phase_sched.sv
// Self-checking bench for intersection_phase_sched with small timing parameters.
// Expected phase segments (phase, clocks) are queued when stimulus is applied and
// compared when the DUT leaves each phase; lamp patterns are checked every cycle.
module tb_intersection_phase_sched;
    logic sys_clk;
    logic sys_rst;

    intersection_phase_sched_if sif ();

    intersection_phase_sched #(
        .TICK_CYCLES (4),
        .T_GREEN_MIN (3),
        .T_B_GREEN   (4),
        .T_AMBER     (2),
        .T_ALLRED    (1)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .sched_if (sif)
    );

    typedef struct {
        logic [2:0] ph;
        int         len;   // negative: length not checked
    } seg_t;

    typedef struct {
        bit side;
        bit ped;
        int offs;        // A_GREEN cycle in which the 1-cycle pulse is driven
        int green_len;   // expected A_GREEN length in clocks
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    seg_t exp_q[$];
    vec_t vecs[5];

    bit         mon_en   = 0;
    bit         seg_open = 0;
    logic [2:0] cur_ph   = '0;
    int         seg_len  = 0;
    int         lamp_bad = 0;

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Lamp table {led_a, led_b, ped_walk} per phase code.
    function automatic logic [6:0] exp_lamps(input logic [2:0] ph);
        case (ph)
            3'd0:    return 7'b110_011_0;
            3'd1:    return 7'b101_011_0;
            3'd2:    return 7'b011_011_0;
            3'd3:    return 7'b011_110_1;
            3'd4:    return 7'b011_101_0;
            3'd5:    return 7'b011_011_0;
            default: return 7'b000_000_0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic close_seg();
        seg_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL seg_unexpected: phase %0d lasted %0d clocks with nothing expected", cur_ph, seg_len);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if ((e.ph != cur_ph) || ((e.len >= 0) && (e.len != seg_len))) begin
                errors++;
                $display("FAIL seg_timing: phase %0d for %0d clocks, expected phase %0d for %0d clocks",
                         cur_ph, seg_len, e.ph, e.len);
            end
            chk($sformatf("seg_lamps_ph%0d", cur_ph), lamp_bad, 0);
        end
    endtask

    initial begin
        forever begin
            @(negedge sys_clk);
            if (!mon_en) begin
                seg_open = 0;
            end else begin
                if (!seg_open || (sif.phase != cur_ph)) begin
                    if (seg_open) close_seg();
                    cur_ph   = sif.phase;
                    seg_len  = 0;
                    lamp_bad = 0;
                    seg_open = 1;
                end
                seg_len++;
                if ({sif.led_a, sif.led_b, sif.ped_walk} !== exp_lamps(cur_ph)) lamp_bad++;
            end
        end
    end

    task automatic wait_phase(input logic [2:0] ph, input int budget);
        bit seen = 0;
        for (int i = 0; (i < budget) && !seen; i++) begin
            @(negedge sys_clk);
            if (sif.phase == ph) seen = 1;
        end
        chk($sformatf("wait_phase%0d", ph), {31'd0, seen}, 1);
    endtask

    task automatic pulse(input bit s, input bit p);
        sif.side_req = s;
        sif.ped_req  = p;
        @(posedge sys_clk);
        #1;
        sif.side_req = 1'b0;
        sif.ped_req  = 1'b0;
    endtask

    task automatic push_bcycle(input int green_len);
        exp_q.push_back('{ph: 3'd0, len: green_len});
        exp_q.push_back('{ph: 3'd1, len: 8});
        exp_q.push_back('{ph: 3'd2, len: 4});
        exp_q.push_back('{ph: 3'd3, len: 16});
        exp_q.push_back('{ph: 3'd4, len: 8});
        exp_q.push_back('{ph: 3'd5, len: 4});
    endtask

    initial begin
        int bad;
        sif.side_req = 1'b0;
        sif.ped_req  = 1'b0;
`ifdef NIGHT_FLASH_EN
        sif.night_mode = 1'b0;
`endif
        sys_rst = 1'b1;

        vecs[0] = '{side: 1, ped: 0, offs: 5,  green_len: 12};
        vecs[1] = '{side: 1, ped: 0, offs: 11, green_len: 12};
        vecs[2] = '{side: 1, ped: 0, offs: 12, green_len: 16};
        vecs[3] = '{side: 1, ped: 1, offs: 19, green_len: 20};
        vecs[4] = '{side: 0, ped: 1, offs: 0,  green_len: 12};

        // Reset state
        repeat (3) @(negedge sys_clk);
        chk("rst_phase", sif.phase, 3'd5);
        chk("rst_led_a", sif.led_a, 3'b011);
        chk("rst_led_b", sif.led_b, 3'b011);
        chk("rst_walk",  sif.ped_walk, 0);

        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        mon_en  = 1;
        exp_q.push_back('{ph: 3'd5, len: 4});

        // Table-driven request timing within A_GREEN
        for (int i = 0; i < 5; i++) begin
            wait_phase(3'd0, 100);
            push_bcycle(vecs[i].green_len);
            if (vecs[i].offs > 0) begin
                repeat (vecs[i].offs) @(posedge sys_clk);
                #1;
            end
            pulse(vecs[i].side, vecs[i].ped);
            wait_phase(3'd3, 100);
        end

        // Pedestrian request during B_GREEN is served after the next minimum green
        @(posedge sys_clk);
        #1;
        pulse(1'b0, 1'b1);
        push_bcycle(12);
        wait_phase(3'd0, 100);
        wait_phase(3'd3, 100);
        wait_phase(3'd0, 100);

        // No requests: A_GREEN holds
        bad = 0;
        repeat (400) begin
            @(negedge sys_clk);
            if ((sif.phase != 3'd0) || (sif.led_a != 3'b110)) bad++;
        end
        chk("hold_green_bad_cycles", bad, 0);
        chk("queue_drained", exp_q.size(), 0);

        // Reset in the middle of B_GREEN with a request pending
        pulse(1'b1, 1'b0);
        exp_q.push_back('{ph: 3'd0, len: -1});
        exp_q.push_back('{ph: 3'd1, len: 8});
        exp_q.push_back('{ph: 3'd2, len: 4});
        wait_phase(3'd3, 100);
        repeat (5) @(posedge sys_clk);
        #1;
        pulse(1'b0, 1'b1);
        @(negedge sys_clk);
        chk("walk_before_rst", sif.ped_walk, 1);
        mon_en  = 0;
        sys_rst = 1'b1;
        #1;
        chk("async_rst_phase", sif.phase, 3'd5);
        chk("async_rst_led_a", sif.led_a, 3'b011);
        chk("async_rst_led_b", sif.led_b, 3'b011);
        chk("async_rst_walk",  sif.ped_walk, 0);
        chk("queue_before_rst", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        mon_en  = 1;
        exp_q.push_back('{ph: 3'd5, len: 4});
        repeat (100) @(negedge sys_clk);
        chk("post_rst_phase", sif.phase, 3'd0);
        chk("post_rst_led_a", sif.led_a, 3'b110);
        chk("post_rst_queue", exp_q.size(), 0);

`ifdef NIGHT_FLASH_EN
        mon_en = 0;
        sif.night_mode = 1'b1;
        wait_phase(3'd6, 5);
        chk("flash_a_on",  sif.led_a, 3'b101);
        chk("flash_b_on",  sif.led_b, 3'b101);
        chk("flash_walk",  sif.ped_walk, 0);
        repeat (4) @(negedge sys_clk);
        chk("flash_a_off", sif.led_a, 3'b111);
        chk("flash_b_off", sif.led_b, 3'b111);
        chk("flash_phase", sif.phase, 3'd6);
        repeat (4) @(negedge sys_clk);
        chk("flash_a_on2", sif.led_a, 3'b101);
        sif.night_mode = 1'b0;
        repeat (4) @(negedge sys_clk);
        chk("unflash_allred_first", sif.phase, 3'd5);
        repeat (3) @(negedge sys_clk);
        chk("unflash_allred_last", sif.phase, 3'd5);
        @(negedge sys_clk);
        chk("unflash_green", sif.phase, 3'd0);
        chk("unflash_led_a", sif.led_a, 3'b110);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
